mmio_gpio_bridge: RTL and testbench

//  Parametrised MMIO slave between RVCORE_TOP EXT_* bus and board I/O. Replaces ad-hoc LED/SW/BTN decode.

---
 rtl/mmio_gpio_pkg.sv | 24 ++
 rtl/gpio_sync_edge.sv | 43 ++++
 rtl/mmio_gpio_bridge.sv | 142 ++++++++++++++
 tb/tb_mmio_gpio_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_gpio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mmio_gpio_pkg                                                 |
// | Brief    : Register offsets and accelerator window defaults for the GPIO |
// |            MMIO bridge.                                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mmio_gpio_pkg;

    typedef enum logic [2:0] {
        REG_LED      = 3'd0,
        REG_SW       = 3'd1,
        REG_BTN      = 3'd2,
        REG_BTN_EDGE = 3'd3,
        REG_IRQ_EN   = 3'd4,
        REG_LED_TGL  = 3'd5,
        REG_CYCLES   = 3'd6
    } reg_off_e;

    localparam int ACC_AW_DEFAULT   = 6;
    localparam int ACC_BASE_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gpio_sync_edge                                                |
// | Brief    : Per-bit input synchroniser with armed rising-edge pulse.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gpio_sync_edge #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         cpu_clk_g,
    input  logic         reset_button,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_level,
    output logic [W-1:0] o_rise
);
    localparam int ARM_W = $clog2(STAGES + 2);
    localparam logic [ARM_W-1:0] C_ARMED = ARM_W'(STAGES + 1);

    logic [STAGES-1:0][W-1:0] r_chain;
    logic [W-1:0]             r_prev;
    logic [ARM_W-1:0]         r_arm;

    always_ff @(posedge cpu_clk_g or posedge reset_button) begin
        if (reset_button) begin
            r_chain <= '0;
            r_prev  <= '0;
            r_arm   <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
            if (r_arm != C_ARMED) begin
                r_arm <= r_arm + 1'b1;
            end
        end
    end

    assign o_level = r_chain[STAGES-1];
    // Suppressed until the chain has flushed, so a level held through reset is not an edge
    assign o_rise  = (r_arm == C_ARMED) ? (o_level & ~r_prev) : '0;

endmodule
`default_nettype wire

// File: rtl/mmio_gpio_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mmio_gpio_bridge                                              |
// | Brief    : EXT_* bus slave for LEDs, switches, buttons, cycle counter    |
// |            and a pass-through accelerator address window.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mmio_gpio_bridge
    import mmio_gpio_pkg::*;
#(
    parameter int AWIDTH      = 16,
    parameter int N_LED       = 4,
    parameter int N_SW        = 4,
    parameter int N_BTN       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACC_AW      = ACC_AW_DEFAULT,
    parameter int ACC_BASE    = ACC_BASE_DEFAULT
) (
    input  logic              cpu_clk_g,
    input  logic              reset_button,
    input  logic              ext_en,
    input  logic [3:0]        ext_wea,
    input  logic [AWIDTH-1:0] ext_addr,
    input  logic [31:0]       ext_din,
    output logic [31:0]       ext_dout,
    input  logic [N_SW-1:0]   switches_in,
    input  logic [N_BTN-1:0]  buttons_in,
    output logic [N_LED-1:0]  leds,
    output logic              irq,
    output logic              acc_en,
    output logic              acc_we,
    output logic [ACC_AW-1:0] acc_addr,
    output logic [31:0]       acc_din,
    input  logic [31:0]       acc_dout
);
    logic [N_SW-1:0]  w_sw_level;
    logic [N_SW-1:0]  w_sw_rise_unused;
    logic [N_BTN-1:0] w_btn_level;
    logic [N_BTN-1:0] w_btn_rise;
    logic [N_LED-1:0] w_led_bm;
    logic [N_BTN-1:0] w_btn_bm;
    logic [N_BTN-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_hit;
    logic             w_rd;
    logic             w_wr;

    logic [N_LED-1:0] r_leds;
    logic [N_BTN-1:0] r_flags;
    logic [N_BTN-1:0] r_irq_en;
    logic             r_irq;
    logic             r_sel_acc;
    logic [31:0]      r_rd;
    logic [31:0]      r_cycles;

    gpio_sync_edge #(.W(N_BTN), .STAGES(SYNC_STAGES)) u_btn_sync (
        .cpu_clk_g    (cpu_clk_g),
        .reset_button (reset_button),
        .i_async      (buttons_in),
        .o_level      (w_btn_level),
        .o_rise       (w_btn_rise)
    );

    gpio_sync_edge #(.W(N_SW), .STAGES(SYNC_STAGES)) u_sw_sync (
        .cpu_clk_g    (cpu_clk_g),
        .reset_button (reset_button),
        .i_async      (switches_in),
        .o_level      (w_sw_level),
        .o_rise       (w_sw_rise_unused)
    );

    // Bit i of each field is governed by the enable of the byte lane it lives in
    for (genvar i = 0; i < N_LED; i++) begin : g_led_bm
        assign w_led_bm[i] = ext_wea[i/8];
    end
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn_bm
        assign w_btn_bm[i] = ext_wea[i/8];
    end

    assign w_hit = (ext_addr[AWIDTH-1:ACC_AW] == (AWIDTH-ACC_AW)'(ACC_BASE));
    assign w_rd  = ext_en && (ext_wea == 4'b0000);
    assign w_wr  = ext_en && (ext_wea != 4'b0000) && !w_hit;
    assign w_clr = (w_wr && (ext_addr == AWIDTH'(REG_BTN_EDGE))) ? (ext_din[N_BTN-1:0] & w_btn_bm) : '0;

    always_comb begin
        w_rdata = '0;
        if (!w_hit) begin
            case (ext_addr)
                AWIDTH'(REG_LED):      w_rdata = 32'(r_leds);
                AWIDTH'(REG_SW):       w_rdata = 32'(w_sw_level);
                AWIDTH'(REG_BTN):      w_rdata = 32'(w_btn_level);
                AWIDTH'(REG_BTN_EDGE): w_rdata = 32'(r_flags);
                AWIDTH'(REG_IRQ_EN):   w_rdata = 32'(r_irq_en);
                AWIDTH'(REG_CYCLES):   w_rdata = r_cycles;
                default:               w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_g or posedge reset_button) begin
        if (reset_button) begin
            r_leds   <= '0;
            r_flags  <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            r_irq    <= |(r_flags & r_irq_en);
            // A new edge in the same cycle as its clear keeps the flag set
            r_flags  <= (r_flags & ~w_clr) | w_btn_rise;
            if (w_wr && (ext_addr == AWIDTH'(REG_LED))) begin
                r_leds <= (r_leds & ~w_led_bm) | (ext_din[N_LED-1:0] & w_led_bm);
            end else if (w_wr && (ext_addr == AWIDTH'(REG_LED_TGL))) begin
                r_leds <= r_leds ^ (ext_din[N_LED-1:0] & w_led_bm);
            end
            if (w_wr && (ext_addr == AWIDTH'(REG_IRQ_EN))) begin
                r_irq_en <= (r_irq_en & ~w_btn_bm) | (ext_din[N_BTN-1:0] & w_btn_bm);
            end
        end
    end

    always_ff @(posedge cpu_clk_g or posedge reset_button) begin
        if (reset_button) begin
            r_rd      <= '0;
            r_sel_acc <= 1'b0;
        end else if (w_rd) begin
            r_rd      <= w_rdata;
            r_sel_acc <= w_hit;
        end
    end

    assign ext_dout = r_sel_acc ? acc_dout : r_rd;
    assign leds     = r_leds;
    assign irq      = r_irq;
    assign acc_en   = ext_en && w_hit;
    assign acc_we   = ext_wea[0];
    assign acc_addr = ext_addr[ACC_AW-1:0];
    assign acc_din  = ext_din;

endmodule
`default_nettype wire

// File: tb/tb_mmio_gpio_bridge.sv
`default_nettype none
// Bench for mmio_gpio_bridge: directed scenarios plus randomized bus and input traffic,
// all checked against a register-level behavioural model.
module tb_mmio_gpio_bridge;
    localparam int S = 2;

    logic        cpu_clk_g    = 1'b0;
    logic        reset_button = 1'b1;
    logic        ext_en       = 1'b0;
    logic [3:0]  ext_wea      = '0;
    logic [15:0] ext_addr     = '0;
    logic [31:0] ext_din      = '0;
    logic [31:0] ext_dout;
    logic [3:0]  switches_in  = '0;
    logic [3:0]  buttons_in   = '0;
    logic [3:0]  leds;
    logic        irq;
    logic        acc_en;
    logic        acc_we;
    logic [5:0]  acc_addr;
    logic [31:0] acc_din;
    logic [31:0] acc_dout     = '0;

    int total = 0;
    int bad   = 0;

    mmio_gpio_bridge dut (
        .cpu_clk_g    (cpu_clk_g),
        .reset_button (reset_button),
        .ext_en       (ext_en),
        .ext_wea      (ext_wea),
        .ext_addr     (ext_addr),
        .ext_din      (ext_din),
        .ext_dout     (ext_dout),
        .switches_in  (switches_in),
        .buttons_in   (buttons_in),
        .leds         (leds),
        .irq          (irq),
        .acc_en       (acc_en),
        .acc_we       (acc_we),
        .acc_addr     (acc_addr),
        .acc_din      (acc_din),
        .acc_dout     (acc_dout)
    );

    always #5 cpu_clk_g = ~cpu_clk_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] acc_fn(input logic [5:0] a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h0101_0101);
    endfunction

    // ---------------- behavioural model ----------------
    int          n_edge = 0;
    logic [3:0]  bh [8];
    logic [3:0]  sh [8];
    logic [3:0]  m_leds = '0, m_flags = '0, m_en = '0;
    logic        m_irq = 1'b0, m_sel = 1'b0;
    logic [31:0] m_rd = '0, m_cyc = '0, m_acc = '0;

    // Synchronised value visible after edge m is the input sampled S-1 edges earlier
    function automatic logic [3:0] sb(input int m);
        if (m < S) return 4'h0;
        return bh[(m - S + 1) % 8];
    endfunction
    function automatic logic [3:0] ss(input int m);
        if (m < S) return 4'h0;
        return sh[(m - S + 1) % 8];
    endfunction

    always @(posedge cpu_clk_g) begin : p_model
        logic        hit, rd, wr, acc_rd;
        logic [3:0]  bm, set, clr;
        logic [31:0] rv;
        hit    = (ext_addr[15:6] == 10'd4);
        acc_rd = 1'b0;
        if (reset_button) begin
            n_edge = 0; m_leds = '0; m_flags = '0; m_en = '0;
            m_irq = 1'b0; m_sel = 1'b0; m_rd = '0; m_cyc = '0;
        end else begin
            n_edge++;
            bh[n_edge % 8] = buttons_in;
            sh[n_edge % 8] = switches_in;
            rd = ext_en && (ext_wea == 4'h0);
            wr = ext_en && (ext_wea != 4'h0) && !hit;
            for (int i = 0; i < 4; i++) bm[i] = ext_wea[i/8];
            if (rd) begin
                rv = '0;
                if (!hit) begin
                    case (ext_addr)
                        16'd0:   rv = 32'(m_leds);
                        16'd1:   rv = 32'(ss(n_edge - 1));
                        16'd2:   rv = 32'(sb(n_edge - 1));
                        16'd3:   rv = 32'(m_flags);
                        16'd4:   rv = 32'(m_en);
                        16'd6:   rv = m_cyc;
                        default: rv = '0;
                    endcase
                end
                m_rd  = rv;
                m_sel = hit;
                if (hit) begin
                    m_acc  = acc_fn(ext_addr[5:0]);
                    acc_rd = 1'b1;
                end
            end
            m_irq   = |(m_flags & m_en);
            set     = (n_edge >= S + 2) ? (sb(n_edge - 1) & ~sb(n_edge - 2)) : 4'h0;
            clr     = (wr && ext_addr == 16'd3) ? (ext_din[3:0] & bm) : 4'h0;
            m_flags = (m_flags & ~clr) | set;
            if (wr && ext_addr == 16'd0) m_leds = (m_leds & ~bm) | (ext_din[3:0] & bm);
            if (wr && ext_addr == 16'd5) m_leds = m_leds ^ (ext_din[3:0] & bm);
            if (wr && ext_addr == 16'd4) m_en   = (m_en & ~bm) | (ext_din[3:0] & bm);
            m_cyc = m_cyc + 32'd1;
        end
        #1;
        if (acc_rd) acc_dout = m_acc;
        #2;
        chk("leds", 32'(leds), 32'(m_leds));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("ext_dout", ext_dout, m_sel ? m_acc : m_rd);
        chk("acc_en", 32'(acc_en), 32'(ext_en && (ext_addr[15:6] == 10'd4)));
        chk("acc_we", 32'(acc_we), 32'(ext_wea[0]));
        chk("acc_addr", 32'(acc_addr), 32'(ext_addr[5:0]));
        chk("acc_din", acc_din, ext_din);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic en, input logic [3:0] wea, input logic [15:0] a, input logic [31:0] d);
        ext_en = en; ext_wea = wea; ext_addr = a; ext_din = d;
        @(negedge cpu_clk_g);
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 4'h0, 16'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset_button = 1'b1;
        idle(3);
        reset_button = 1'b0;
    endtask

    initial begin
        logic [5:0]  r;
        logic [15:0] a;
        logic [3:0]  w;
        int          sel;
        @(negedge cpu_clk_g);
        idle(2);
        reset_button = 1'b0;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_dout", ext_dout, 32'h0);

        // LED write and readback
        drive(1'b1, 4'h1, 16'd0, 32'hF);
        chk("t1_leds", 32'(leds), 32'hF);
        drive(1'b1, 4'h0, 16'd0, 32'h0);
        chk("t1_read", ext_dout, 32'hF);

        // wea=0 is a read, then toggle
        drive(1'b1, 4'h0, 16'd0, 32'hA);
        chk("t2_noweа_leds", 32'(leds), 32'hF);
        drive(1'b1, 4'h1, 16'd5, 32'h3);
        chk("t2_tgl_leds", 32'(leds), 32'hC);
        drive(1'b1, 4'h0, 16'd5, 32'h0);
        chk("t2_tgl_read", ext_dout, 32'h0);

        // Button edge flag, mask, irq, W1C
        idle(2);
        buttons_in = 4'b0010;
        idle(S + 1);
        drive(1'b1, 4'h0, 16'd3, 32'h0);
        chk("t3_flag", ext_dout, 32'h2);
        chk("t3_irq_masked", 32'(irq), 32'h0);
        drive(1'b1, 4'h1, 16'd4, 32'h2);
        idle(1);
        chk("t3_irq_on", 32'(irq), 32'h1);
        drive(1'b1, 4'h1, 16'd3, 32'h2);
        idle(1);
        chk("t3_irq_off", 32'(irq), 32'h0);
        drive(1'b1, 4'h0, 16'd3, 32'h0);
        chk("t3_flag_clr", ext_dout, 32'h0);

        // Set wins over simultaneous clear
        buttons_in = 4'b0110;
        idle(2);
        drive(1'b1, 4'h1, 16'd3, 32'h4);
        drive(1'b1, 4'h0, 16'd3, 32'h0);
        chk("t4_set_wins", ext_dout, 32'h4);

        // Button held through reset gives no flag
        buttons_in = 4'b1110;
        do_reset();
        idle(6);
        drive(1'b1, 4'h0, 16'd3, 32'h0);
        chk("t4_held_reset", ext_dout, 32'h0);
        drive(1'b1, 4'h0, 16'd2, 32'h0);
        chk("t4_btn_level", ext_dout, 32'hE);
        buttons_in = 4'h0;

        // Accelerator window
        drive(1'b1, 4'h1, 16'd0, 32'h5);
        r = 6'($urandom_range(0, 63));
        ext_en = 1'b1; ext_wea = 4'h0; ext_addr = 16'h0100 | 16'(r); ext_din = 32'h0;
        #1;
        chk("t5_acc_en", 32'(acc_en), 32'h1);
        chk("t5_acc_addr", 32'(acc_addr), 32'(r));
        @(negedge cpu_clk_g);
        chk("t5_acc_dout", ext_dout, acc_fn(r));
        ext_en = 1'b1; ext_wea = 4'h1; ext_addr = 16'h0100; ext_din = 32'hA;
        #1;
        chk("t5_acc_we", 32'(acc_we), 32'h1);
        @(negedge cpu_clk_g);
        chk("t5_leds_kept", 32'(leds), 32'h5);
        drive(1'b1, 4'h0, 16'h0140, 32'h0);
        chk("t5_outside", ext_dout, 32'h0);

        // Counter wrap, then reset in the middle of a read
        force dut.r_cycles = 32'hFFFF_FFFE;
        release dut.r_cycles;
        m_cyc = 32'hFFFF_FFFE;
        drive(1'b1, 4'h0, 16'd6, 32'h0);
        chk("t6_cyc0", ext_dout, 32'hFFFF_FFFE);
        drive(1'b1, 4'h0, 16'd6, 32'h0);
        chk("t6_cyc1", ext_dout, 32'hFFFF_FFFF);
        drive(1'b1, 4'h0, 16'd6, 32'h0);
        chk("t6_cyc_wrap", ext_dout, 32'h0);
        drive(1'b1, 4'h0, 16'd0, 32'h0);
        ext_en = 1'b0;
        #2 reset_button = 1'b1;
        #1;
        chk("t6_rst_dout", ext_dout, 32'h0);
        chk("t6_rst_leds", 32'(leds), 32'h0);
        @(negedge cpu_clk_g);
        reset_button = 1'b0;
        idle(1);
        chk("t6_after_rst", ext_dout, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                7:       a = 16'h0100 | 16'($urandom_range(0, 63));
                8:       a = 16'($urandom);
                default: a = 16'(sel);
            endcase
            w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) buttons_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) switches_in = 4'($urandom);
            if (i == 400) do_reset();
            drive($urandom_range(0, 3) != 0, w, a, $urandom);
        end
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
